pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an arbitrary-width packed payload between two stages using a valid/ready handshake.
- A two-entry skid buffer lets in_ready be registered while still sustaining one transfer per clock.
- A synchronous flush inserts a bubble. In the bubble, out_data equals BUBBLE_VAL, the same all-zero NOP the fixed registers produce.

---
 rtl/pipe_stage_skid.sv | 165 ++++++++++++++++
 tb/tb_pipe_stage_skid.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a two-entry skid buffer.
// The main register drives the outputs and the skid register catches the one
// payload that can arrive while in_ready is registered low. Any slot that does
// not hold a valid payload holds BUBBLE_VAL. A synchronous flush returns the
// stage to EMPTY.
// Optional feature macro: PIPE_STAGE_SKID_PERF_EN. When it is defined,
// stall_cnt and flush_cnt are saturating counters. When it is undefined, both
// ports are tied to zero and no counter flops exist.
module pipe_stage_skid #(
  parameter int unsigned          DATA_W     = 32,
  parameter logic [DATA_W-1:0]    BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int unsigned          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // The state encoding is {skid_v, main_v}. Encoding 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;

  logic               main_v;
  logic               skid_v;
  logic               accept;
  logic               pop;

  assign main_v    = state_q[0];
  assign skid_v    = state_q[1];

  assign in_ready  = ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

  assign accept    = in_valid & in_ready;
  assign pop       = main_v & out_ready;

  // Next-state and datapath selection; flush overrides every handshake.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_data_d = in_data;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (pop && accept) begin
          main_data_d = in_data;
        end else if (pop) begin
          main_data_d = BUBBLE_VAL;
          state_d     = EMPTY;
        end else if (accept) begin
          skid_data_d = in_data;
          state_d     = FULL;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can move the state.
        if (pop) begin
          main_data_d = skid_data_q;
          skid_data_d = BUBBLE_VAL;
          state_d     = BUSY;
        end
      end
      default: begin
        // Recover from the unreachable encoding by emptying both slots.
        main_data_d = BUBBLE_VAL;
        skid_data_d = BUBBLE_VAL;
        state_d     = EMPTY;
      end
    endcase

    if (flush) begin
      main_data_d = BUBBLE_VAL;
      skid_data_d = BUBBLE_VAL;
      state_d     = EMPTY;
    end
  end

  // State and payload registers. The data registers also reset so that
  // out_data shows the bubble value immediately when rst is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= BUBBLE_VAL;
      skid_data_q <= BUBBLE_VAL;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_SKID_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Count stalled cycles, and count flushes that discarded at least one entry.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_v && !out_ready) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
    if (flush && (state_q != EMPTY)) begin
      flush_cnt_d = sat_inc(flush_cnt_q);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

  // An empty main slot must always present the bubble value.
  a_bubble_when_idle : assert property (
    @(posedge clk) disable iff (rst) !main_v |-> (main_data_q == BUBBLE_VAL)
  );

  // The {skid_v, main_v} = 2'b10 encoding is never reached.
  a_no_illegal_state : assert property (
    @(posedge clk) disable iff (rst) state_q != 2'b10
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid, built with DATA_W=16 and CNT_W=4.
// It works whether or not PIPE_STAGE_SKID_PERF_EN is defined.
module tb_pipe_stage_skid;

  localparam int DW = 16;
  localparam int CW = 4;
`ifdef PIPE_STAGE_SKID_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // On every cycle, out_data must be the bubble value whenever out_valid is low.
  always @(negedge clk) begin
    if (!out_valid) begin
      checks++;
      if (out_data !== '0) begin
        errors++;
        $display("FAIL invariant_bubble t=%0t out_data=%h required=0", $time, out_data);
      end
    end
  end

  // Stop the run if it ever exceeds its time limit.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Advance one clock edge, then settle, so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    rst = 1'b0;
    step();
    checks++;
    if ({out_valid, in_ready, occupancy} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_ctrl v/r/occ=%b%b%0d required=0 1 0", out_valid, in_ready, occupancy);
    end
    checks++;
    if (out_data !== 16'h0000 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_data data=%h stall=%0d flush=%0d required=0 0 0", out_data, stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vec [3];
    vec[0] = 16'h0011; vec[1] = 16'h0022; vec[2] = 16'h0033;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vec[i];
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== vec[i] || in_ready !== 1'b1 || occupancy !== 2'd1) begin
        errors++;
        $display("FAIL stream_%0d v=%b data=%h rdy=%b occ=%0d required v=1 data=%h rdy=1 occ=1",
                 i, out_valid, out_data, in_ready, occupancy, vec[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stream_drain v=%b occ=%0d stall=%0d required 0 0 0", out_valid, occupancy, stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_out [3];
    exp_out[0] = 16'h00A2; exp_out[1] = 16'h00A3; exp_out[2] = 16'h0000;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00A1;
    step();
    checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 16'h00A1) begin
      errors++;
      $display("FAIL bp_first occ=%0d rdy=%b data=%h required 1 1 00a1", occupancy, in_ready, out_data);
    end
    in_data = 16'h00A2;
    step();
    checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 16'h00A1) begin
      errors++;
      $display("FAIL bp_full occ=%0d rdy=%b data=%h required 2 0 00a1", occupancy, in_ready, out_data);
    end
    in_data   = 16'h00A3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 1) in_valid = 1'b0;
      checks++;
      if (out_data !== exp_out[i] || out_valid !== (i < 2)) begin
        errors++;
        $display("FAIL bp_order_%0d data=%h v=%b required data=%h v=%b",
                 i, out_data, out_valid, exp_out[i], (i < 2));
      end
    end
    checks++;
    if (stall_cnt !== (PERF ? 4'd1 : 4'd0) || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall_cnt stall=%0d rdy=%b required %0d 1", stall_cnt, in_ready, PERF ? 1 : 0);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00B1;
    step();
    in_data = 16'h00B2;
    step();
    checks++;
    if (occupancy !== 2'd2) begin
      errors++;
      $display("FAIL flush_setup occ=%0d required 2", occupancy);
    end
    flush   = 1'b1;
    in_data = 16'h00B3;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_bubble occ=%0d v=%b data=%h rdy=%b required 0 0 0000 1",
               occupancy, out_valid, out_data, in_ready);
    end
    checks++;
    if (flush_cnt !== (PERF ? 4'd1 : 4'd0) || stall_cnt !== (PERF ? 4'd2 : 4'd0)) begin
      errors++;
      $display("FAIL flush_counters flush=%0d stall=%0d required %0d %0d",
               flush_cnt, stall_cnt, PERF ? 1 : 0, PERF ? 2 : 0);
    end
    out_ready = 1'b1;
    step(); step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL flush_no_b3 v=%b data=%h required v=0", out_valid, out_data);
    end
  endtask

  task automatic test_flush_empty();
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || flush_cnt !== (PERF ? 4'd1 : 4'd0)) begin
      errors++;
      $display("FAIL flush_empty occ=%0d v=%b flush=%0d required 0 0 %0d",
               occupancy, out_valid, flush_cnt, PERF ? 1 : 0);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00C1;
    step();
    in_data = 16'h00C2;
    step();
    in_valid = 1'b0;
    checks++;
    if (occupancy !== 2'd2 || out_data !== 16'h00C1) begin
      errors++;
      $display("FAIL arst_setup occ=%0d data=%h required 2 00c1", occupancy, out_data);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL arst_immediate v=%b rdy=%b occ=%0d data=%h required 0 1 0 0000",
               out_valid, in_ready, occupancy, out_data);
    end
    checks++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      errors++;
      $display("FAIL arst_counters stall=%0d flush=%0d required 0 0", stall_cnt, flush_cnt);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      errors++;
      $display("FAIL arst_after v=%b occ=%0d required 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_stall_saturation();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00D1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 5 || i == 16 || i == 20) begin
        checks++;
        if (stall_cnt !== (PERF ? CW'((i > 15) ? 15 : i) : 4'd0)) begin
          errors++;
          $display("FAIL stall_sat_%0d stall=%0d required %0d",
                   i, stall_cnt, PERF ? ((i > 15) ? 15 : i) : 0);
        end
      end
    end
    checks++;
    if (out_data !== 16'h00D1 || occupancy !== 2'd1) begin
      errors++;
      $display("FAIL stall_hold data=%h occ=%0d required 00d1 1", out_data, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_flush_empty();
    test_async_reset();
    test_stall_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
